memory_arbiter: RTL

Single-port RAM arbiter between the instruction and data cache sides of the pipelined CPU. It accepts one instruction-fetch requester and one data load/store requester and grants the RAM to one of them at a time through a registered state machine. It returns per-requester wait/data and keeps data accesses prioritised without starving fetch. It also retries RAM errors and aborts accesses that stall longer than a watchdog limit.

---
 rtl/memory_arbiter_pkg.sv | 42 ++++
 rtl/memory_arbiter_if.sv | 46 ++++
 rtl/memory_arbiter_watchdog.sv | 43 ++++
 rtl/memory_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Purpose : shared types and constants for the instruction/data RAM arbiter.
// Latency : n/a (declarations only).
// Backpr. : n/a (declarations only).
//
// Contents: RAM handshake state, arbiter FSM state constants, grant record,
// abort data word and small state-decode helpers.
package memory_arbiter_pkg;

  // RAM-side status reported every cycle by the memory model/controller.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter FSM encoding. Kept as plain constants so the registered state
  // can be probed and compared by legacy tooling without enum casts.
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] I_ACC = 2'd1;
  localparam logic [1:0] D_RD  = 2'd2;
  localparam logic [1:0] D_WR  = 2'd3;

  // Returned on the load bus of a requester whose access was aborted.
  localparam logic [31:0] ABORT_WORD = 32'hBAD0_BAD0;

  // Everything latched on the grant edge: target state, address, store data.
  typedef struct packed {
    logic [1:0]  state;
    logic [31:0] addr;
    logic [31:0] store;
  } grant_t;

  function automatic logic is_acc_state(input logic [1:0] s);
    return s != IDLE;
  endfunction

  function automatic logic is_data_state(input logic [1:0] s);
    return (s == D_RD) || (s == D_WR);
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Purpose : bundles the instruction cache, data cache and RAM signals of the arbiter.
// Latency : n/a (wiring only).
// Backpr. : valid/wait; a requester holds its request until it sees its wait low.
//
// Ports (slave = arbiter view):
//   iREN/iaddr -> iwait/iload        instruction fetch side
//   dREN/dWEN/daddr/dstore -> dwait/dload   data load/store side
//   ramREN/ramWEN/ramaddr/ramstore -> RAM, ramload/ramstate <- RAM
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;

  // instruction cache side
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  // data cache side
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  // RAM side
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  // The arbiter itself.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // The surrounding environment: both caches plus the RAM.
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/memory_arbiter_watchdog.sv
// Purpose : per-access stall counter; flags an access the RAM has not served in TIMEOUT cycles.
// Latency : o_expire is combinational from the registered count.
// Backpr. : none; counting freezes once the limit is reached until the next clear.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   i_clear    start of a new access (grant edge), zeroes the count
//   i_enable   an access is in progress this cycle
//   i_hit      RAM reports ACCESS this cycle (no increment)
//   o_expire   count has reached TIMEOUT while an access is in progress
module memory_arbiter_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_hit,
  output logic o_expire
);

  localparam int          CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_wd_cnt;
  logic          w_at_limit;

  assign w_at_limit = (r_wd_cnt == LIMIT);
  assign o_expire   = i_enable && w_at_limit;

  // Saturating at LIMIT keeps the counter from wrapping if the owner is
  // slow to leave the access state after expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (i_clear) begin
      r_wd_cnt <= '0;
    end else if (i_enable && !i_hit && !w_at_limit) begin
      r_wd_cnt <= r_wd_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Purpose : grants a single-port RAM to the instruction or data requester, data first with
//           a starvation override for fetch, automatic retry on ERROR and a stall watchdog.
// Latency : request seen in IDLE -> strobes next cycle; wait drops combinationally on ACCESS.
// Backpr. : valid/wait; requests arriving during an access wait for the next IDLE cycle.
//
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   bus           memory_arbiter_if.slave (cache request/response and RAM signals)
//   timeout_err   sticky: some access was aborted by the watchdog; cleared by RST only
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic            CLK,
  input  logic            RST,
  memory_arbiter_if.slave bus,
  output logic            timeout_err
);

  localparam int            SW   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  // registered state
  logic [1:0]    r_state;
  logic [31:0]   r_ramaddr;
  logic [31:0]   r_ramstore;
  logic [SW-1:0] r_starve_cnt;
  logic          r_timeout_err;

  // combinational
  grant_t        w_grant;
  logic          w_grant_vld;
  logic          w_starved;
  logic          w_in_acc;
  logic          w_access;
  logic          w_expire;
  logic          w_abort;
  logic          w_done;
  logic          w_i_done;
  logic          w_d_done;
  logic [31:0]   w_done_data;
  logic [1:0]    w_state_nxt;
  logic          w_grant_is_d;

  // ---------------------------------------------------------------------------
  // Arbitration (only acted upon in IDLE)
  // ---------------------------------------------------------------------------
  assign w_starved = bus.iREN && (r_starve_cnt == SMAX);

  always_comb begin
    w_grant       = '0;
    w_grant.state = IDLE;
    if (w_starved) begin
      w_grant.state = I_ACC;
    end else if (bus.dWEN) begin
      // a simultaneous dREN is ignored: the store goes first
      w_grant.state = D_WR;
    end else if (bus.dREN) begin
      w_grant.state = D_RD;
    end else if (bus.iREN) begin
      w_grant.state = I_ACC;
    end
    w_grant.addr  = (w_grant.state == I_ACC) ? bus.iaddr : bus.daddr;
    w_grant.store = bus.dstore;
  end

  assign w_grant_vld  = (r_state == IDLE) && (w_grant.state != IDLE);
  assign w_grant_is_d = is_data_state(w_grant.state);

  // ---------------------------------------------------------------------------
  // Access completion
  // ---------------------------------------------------------------------------
  assign w_in_acc = is_acc_state(r_state);
  assign w_access = w_in_acc && (bus.ramstate == ACCESS);
  // ACCESS in the same cycle the watchdog reaches its limit is a success.
  assign w_abort  = w_expire && !w_access;
  assign w_done   = w_access || w_abort;

  assign w_i_done    = (r_state == I_ACC) && w_done;
  assign w_d_done    = is_data_state(r_state) && w_done;
  assign w_done_data = w_abort ? ABORT_WORD : bus.ramload;

  memory_arbiter_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (CLK),
    .rst      (RST),
    .i_clear  (w_grant_vld),
    .i_enable (w_in_acc),
    .i_hit    (w_access),
    .o_expire (w_expire)
  );

  // ---------------------------------------------------------------------------
  // FSM: IDLE -> one ACC state -> IDLE. ERROR/BUSY/FREE simply hold the
  // ACC state, which keeps the strobes up and retries the same access.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE) begin
      w_state_nxt = w_grant.state;
    end else if (w_done) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_ramaddr  <= '0;
      r_ramstore <= '0;
    end else begin
      r_state <= w_state_nxt;
      // address/data frozen for the whole access
      if (w_grant_vld) begin
        r_ramaddr  <= w_grant.addr;
        r_ramstore <= w_grant.store;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation counter: data grants taken while a fetch was waiting.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_starve_cnt <= '0;
    end else if (r_state == IDLE) begin
      if (w_grant.state == I_ACC || !bus.iREN) begin
        r_starve_cnt <= '0;
      end else if (w_grant_is_d && (r_starve_cnt != SMAX)) begin
        r_starve_cnt <= r_starve_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_timeout_err <= 1'b0;
    end else if (w_abort) begin
      r_timeout_err <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Waits follow the live request so a requester that dropped its
  // request mid-access never sees a stray completion pulse.
  // ---------------------------------------------------------------------------
  assign bus.ramREN   = (r_state == I_ACC) || (r_state == D_RD);
  assign bus.ramWEN   = (r_state == D_WR);
  assign bus.ramaddr  = r_ramaddr;
  assign bus.ramstore = r_ramstore;

  assign bus.iwait = bus.iREN && !w_i_done;
  assign bus.dwait = (bus.dREN || bus.dWEN) && !w_d_done;
  assign bus.iload = w_i_done ? w_done_data : '0;
  assign bus.dload = w_d_done ? w_done_data : '0;

  assign timeout_err = r_timeout_err;

endmodule
